pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised, elastic inter-stage pipeline register for the multi-cycle/pipelined MIPS core. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. The block carries a data bundle and a control bundle, adds a valid/ready handshake, a 2-entry skid buffer for stall absorption, and a synchronous flush. Control bits are forced to zero whenever the stage holds a bubble, so write enables never fire spuriously.

Parameters:
DATA_W, 101, width of the data bundle (PC, ALU result, store data, destination register, …).
CTRL_W, 5, width of the control bundle (MemRead, MemWrite, MemtoReg, RegWrite, …); all bits are zeroed on a bubble.
CNT_W, 16, width of the performance counters (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous kill of stage contents (branch/exception).
in_valid  in  1  upstream holds a valid instruction.
in_ready  out  1  stage can accept this cycle.
in_data  in  DATA_W  upstream data bundle.
in_ctrl  in  CTRL_W  upstream control bundle.
out_valid  out  1  stage output holds a valid instruction.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DATA_W  registered data bundle.
out_ctrl  out  CTRL_W  registered control bundle; 0 whenever out_valid=0.

Behaviour:
- State register, 3 states: EMPTY (nothing held), BUSY (output register valid), FULL (output register and skid register both valid).
- in_ready = (state != FULL). It is decoded from registers only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_ctrl = out_valid ? ctrl_reg : 0.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY: accept -> BUSY, output register loads the input.
- BUSY:
  - accept & drain -> BUSY, output register loads the input.
  - accept & !drain -> FULL, skid register loads the input.
  - !accept & drain -> EMPTY.
  - otherwise hold.
- FULL: drain -> BUSY, output register loads the skid register; otherwise hold. No accept is possible in FULL.
- Latency: 1 cycle from accept to out_valid with an empty stage. Throughput: 1 instruction per cycle with out_ready held high.
- flush has the highest priority over every transition. The next state is EMPTY and any same-cycle accept is discarded. The cycle after flush: out_valid=0, out_ctrl=0, in_ready=1.
- A flush coinciding with a drain is allowed: the downstream consumes the current output that cycle, then the stage is empty.
- Data registers are not cleared by flush or drain; out_data holds its last value and is don't-care while out_valid=0.
- Reset (async, any time, including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_ctrl=0, out_data=0, skid registers=0.
  - Performance counters=0.
  - The first accept occurs on the first rising clk edge after reset deasserts.
- No ordering reversal: the skid entry always leaves after the output-register entry.

Optional Feature:
Macro STAGE_PERF_CNT_EN.
- Defined: two extra outputs, stall_cnt[CNT_W] and bubble_cnt[CNT_W].
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - bubble_cnt increments on each cycle with out_ready & !out_valid.
  - Both counters saturate at all-ones, never wrap, and are cleared by reset only (not by flush).
- Undefined: the ports and counter logic are absent; the rest of the behaviour is identical.

Test Plan:
1. Reset asserted mid-stream with FULL state -> same cycle: out_valid=0, out_ctrl=0, in_ready=1, out_data=0. After release, in_data=32'h0040_0004-based bundle accepted -> appears next cycle.
2. Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, no gaps.
3. Stall: load A, then B with out_ready=0 -> state FULL, in_ready=0, out_data=A held. Raise out_ready -> A, then B on the next cycle, then out_valid=0.
4. Flush while FULL, with in_valid=1 carrying C -> next cycle out_valid=0 and out_ctrl=0 even though ctrl_reg held 5'b11111. C is never output.
5. Bubble gating: in_ctrl=5'b10101 with in_valid=0 -> out_ctrl stays 0 and out_valid stays 0.
6. With STAGE_PERF_CNT_EN and CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt reads 3 (saturated), not 1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Latency: 1 cycle from accept to out_valid when the stage is empty. Sustains 1 instruction/cycle.
// Backpressure: in_ready is decoded from registered state only (low when both entries are held), so
//   there is no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   flush                 synchronous kill of the stage contents; beats any accept
//   in_valid/in_ready     upstream handshake; in_data/in_ctrl carry the bundles
//   out_valid/out_ready   downstream handshake; out_data/out_ctrl are registered
//   stall_cnt, bubble_cnt saturating performance counters (only with STAGE_PERF_CNT_EN)
//
// Optional feature macro: STAGE_PERF_CNT_EN adds the stall/bubble counters and their ports.
// out_ctrl is forced to zero whenever the stage holds a bubble, so downstream write enables
// can never fire from stale control bits.

module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // EMPTY: nothing held. BUSY: output register valid. FULL: output and skid registers valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic drain;
  logic ld_out_from_in;
  logic ld_out_from_skid;
  logic ld_skid;

  // Handshake decode straight from the state register.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Next-state and register-load decode.
  always_comb begin
    state_nxt        = state;
    ld_out_from_in   = 1'b0;
    ld_out_from_skid = 1'b0;
    ld_skid          = 1'b0;

    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt      = BUSY;
          ld_out_from_in = 1'b1;
        end
      end
      BUSY: begin
        if (accept && drain) begin
          ld_out_from_in = 1'b1;
        end else if (accept) begin
          // Output register is still waiting; park the newcomer behind it.
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // The older output entry leaves first, then the skid entry moves up: order is kept.
        if (drain) begin
          state_nxt        = BUSY;
          ld_out_from_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase

    // Flush wins over everything: the stage empties and a same-cycle accept is dropped.
    // A drain in the same cycle still completes because downstream samples the current output.
    if (flush) begin
      state_nxt        = EMPTY;
      ld_out_from_in   = 1'b0;
      ld_out_from_skid = 1'b0;
      ld_skid          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data registers are only loaded, never cleared by flush/drain; validity lives in the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      ctrl_reg <= '0;
    end else if (ld_out_from_in) begin
      data_reg <= in_data;
      ctrl_reg <= in_ctrl;
    end else if (ld_out_from_skid) begin
      data_reg <= skid_data;
      ctrl_reg <= skid_ctrl;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (ld_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end
  end

  assign out_data = data_reg;
  // Bubble gating: stale ctrl_reg bits must never reach the next stage's write enables.
  assign out_ctrl = out_valid ? ctrl_reg : '0;

`ifdef STAGE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Both counters saturate at all-ones and are cleared by reset only (flush leaves them alone).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end
`else
  // Counter width is meaningless without the counters; keep the parameter referenced.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
